// File: rtl/dma_pkg.sv
// Shared definitions for the DMA blocks: FSM state encoding, FP16 address step and
// the memory-map base addresses used by the command sequencer.
package dma_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StFin   = 2'd3
    } dma_state_e;

    localparam int unsigned ADDR_STEP_FP16 = 2;

    localparam logic [31:0] CMD_BASE    = 32'h0000_0000;
    localparam logic [31:0] WEIGHT_BASE = 32'h0000_1000;
    localparam logic [31:0] IMAGE_BASE  = 32'h0029_0000;
    localparam logic [31:0] OUTBUF_BASE = 32'h002E_0000;

    // Occupancy counters need one extra bit to represent a full buffer.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop, empty/full flags and occupancy count.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import dma_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned AddrW     = $clog2(FIFO_DEPTH),
    localparam int unsigned CntW      = cnt_width(FIFO_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            pop_i,
    output logic [DW-1:0]   rdata_o,
    output logic            empty_o,
    output logic            full_o,
    output logic [CntW-1:0] count_o
);

    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    logic [DW-1:0]    mem_q [FIFO_DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DepthC);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage is not reset; the count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_rd_resp.sv
// Read-side DMA responder: splits a request into single-word memory reads, buffers the
// returns and streams them out. Define DMA_RD_PERF_EN to build the busy-cycle counter.
module dma_rd_resp
    import dma_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 32,
    parameter int unsigned ADDR_STEP  = ADDR_STEP_FP16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_re,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_len,
    output logic          req_busy,
    output logic          req_err,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_wait,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          done,
    output logic [31:0]   perf_cycles
);

    localparam int unsigned     CntW   = cnt_width(FIFO_DEPTH);
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    dma_state_e      state_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      len_q, issue_q, pop_cnt_q;
    logic [CntW-1:0] inflight_q;
    logic            err_q;

    logic            accept, pop, push;
    logic [DW-1:0]   fifo_rdata;
    logic            fifo_empty, fifo_full;
    logic [CntW-1:0] fifo_count;

    // inflight covers outstanding reads plus buffered words, so the FIFO can never overflow.
    assign mem_rd   = (state_q == StIssue) && (inflight_q < DepthC);
    assign mem_addr = addr_q;
    assign accept   = mem_rd & ~mem_wait;

    assign req_busy = (state_q == StIssue) || (state_q == StDrain);
    assign req_err  = err_q;
    assign done     = (state_q == StFin);

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_empty ? '0 : fifo_rdata;
    assign out_last  = out_valid && (pop_cnt_q == len_q - 8'd1);
    assign pop       = out_valid & out_ready;

    // Returns outside a transfer are stale and dropped.
    assign push = mem_rvalid & req_busy & ~fifo_full;

    sync_fifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (mem_rdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            issue_q    <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q      <= req_re && (state_q != StIdle);
            inflight_q <= inflight_q + CntW'(accept) - CntW'(pop);
            if (pop) pop_cnt_q <= pop_cnt_q + 8'd1;

            unique case (state_q)
                StIdle: begin
                    if (req_re) begin
                        if (req_len != 8'd0) begin
                            addr_q    <= req_addr;
                            len_q     <= req_len;
                            issue_q   <= req_len;
                            pop_cnt_q <= '0;
                            state_q   <= StIssue;
                        end else begin
                            state_q <= StFin;
                        end
                    end
                end
                StIssue: begin
                    if (accept) begin
                        addr_q  <= addr_q + AW'(ADDR_STEP);
                        issue_q <= issue_q - 8'd1;
                        if (issue_q == 8'd1) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // No new commands here, so the last credit returning means the final pop.
                    if (pop && (inflight_q == CntW'(1))) state_q <= StFin;
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef DMA_RD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (req_busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_rd_resp.sv
// Directed bench for dma_rd_resp with a 1-cycle-latency memory model and a scoreboard of
// expected addresses and stream beats.
module tb_dma_rd_resp;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk, rst_n;
    logic        req_re;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        req_busy, req_err, mem_rd;
    logic [31:0] mem_addr;
    logic        mem_wait, mem_rvalid;
    logic [15:0] mem_rdata;
    logic        out_valid, out_last, out_ready, done;
    logic [15:0] out_data;
    logic [31:0] perf_cycles;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_count   = 0;
    int pops        = 0;
    int last_pop_cyc = -10;

    logic [31:0] exp_addr_q[$];
    beat_t       exp_beat_q[$];

    logic        acc_valid = 1'b0;
    logic [31:0] acc_addr  = '0;

    dma_rd_resp #(
        .DW         (16),
        .AW         (32),
        .ADDR_STEP  (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_re      (req_re),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_busy    (req_busy),
        .req_err     (req_err),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_wait    (mem_wait),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .done        (done),
        .perf_cycles (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model and scoreboard: drive returns at negedge, sample at negedge+1.
    always @(negedge clk) begin
        mem_rvalid = acc_valid;
        mem_rdata  = mem_word(acc_addr);
        #1;
        cyc++;
        acc_valid = 1'b0;
        if (rst_n && mem_rd && !mem_wait) begin
            acc_valid = 1'b1;
            acc_addr  = mem_addr;
            acc_count++;
            if (exp_addr_q.size() == 0) chk("addr_unexpected", 32'(exp_addr_q.size()), 32'd1);
            else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (rst_n && out_valid && out_ready) begin
            pops++;
            if (exp_beat_q.size() == 0) begin
                chk("beat_unexpected", 32'(exp_beat_q.size()), 32'd1);
            end else begin
                beat_t b;
                b = exp_beat_q.pop_front();
                chk("out_data", {16'h0, out_data}, {16'h0, b.data});
                chk("out_last", {31'h0, out_last}, {31'h0, b.last});
                if (b.last) last_pop_cyc = cyc;
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input logic [7:0] n);
        beat_t b;
        @(negedge clk);
        req_re   = 1'b1;
        req_addr = a;
        req_len  = n;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr_q.push_back(a + 32'(2 * i));
            b.data = mem_word(a + 32'(2 * i));
            b.last = (i == int'(n) - 1);
            exp_beat_q.push_back(b);
        end
        @(negedge clk);
        req_re = 1'b0;
    endtask

    // Caller must be in the first half of a low clock phase.
    task automatic wait_done(input string tag, input int budget, output int done_at);
        logic seen = 1'b0;
        done_at = -1;
        for (int k = 0; k < budget; k++) begin
            #2;
            if (done) begin
                seen    = 1'b1;
                done_at = cyc;
                break;
            end
            @(negedge clk);
        end
        chk(tag, {31'h0, seen}, 32'd1);
        @(negedge clk);
        #2;
        chk({tag, "_single"}, {31'h0, done}, 32'd0);
        chk({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
        chk({tag, "_beat_left"}, 32'(exp_beat_q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, req_busy}, 32'd0);
        chk({tag, "_err"}, {31'h0, req_err}, 32'd0);
        chk({tag, "_mem_rd"}, {31'h0, mem_rd}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {16'h0, out_data}, 32'd0);
        chk({tag, "_out_last"}, {31'h0, out_last}, 32'd0);
        chk({tag, "_done"}, {31'h0, done}, 32'd0);
        chk({tag, "_perf"}, perf_cycles, 32'd0);
    endtask

    initial begin
        int t;
        rst_n     = 1'b0;
        req_re    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        mem_wait  = 1'b0;
        out_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        #2;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic read with a free-flowing consumer.
        @(negedge clk);
        out_ready = 1'b1;
        start_req(32'h0029_0000, 8'd4);
        #2;
        chk("basic_busy", {31'h0, req_busy}, 32'd1);
        chk("basic_first_rd", {31'h0, mem_rd}, 32'd1);
        chk("basic_first_addr", mem_addr, 32'h0029_0000);
        wait_done("basic_done", 40, t);
        chk("basic_done_after_pop", 32'(t), 32'(last_pop_cyc + 1));
`ifdef DMA_RD_PERF_EN
        chk("perf_counting", {31'h0, perf_cycles != 32'd0}, 32'd1);
`else
        chk("perf_tied", perf_cycles, 32'd0);
`endif

        // Back-pressure: only FIFO_DEPTH commands may be in flight.
        @(negedge clk);
        out_ready = 1'b0;
        acc_count = 0;
        pops      = 0;
        start_req(32'h0000_1000, 8'd16);
        repeat (20) @(negedge clk);
        #2;
        chk("bp_accepts", 32'(acc_count), 32'd4);
        chk("bp_mem_rd_low", {31'h0, mem_rd}, 32'd0);
        chk("bp_head_valid", {31'h0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        wait_done("bp_done", 200, t);
        chk("bp_pops", 32'(pops), 32'd16);

        // Stall and address wrap.
        @(negedge clk);
        mem_wait = 1'b1;
        start_req(32'hFFFF_FFFE, 8'd2);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_rd", {31'h0, mem_rd}, 32'd1);
            chk("stall_addr", mem_addr, 32'hFFFF_FFFE);
            @(negedge clk);
        end
        mem_wait = 1'b0;
        wait_done("wrap_done", 40, t);

        // Empty transfer: no memory traffic, quick done.
        @(negedge clk);
        acc_count = 0;
        start_req(32'h0000_2000, 8'd0);
        #2;
        chk("len0_busy", {31'h0, req_busy}, 32'd0);
        wait_done("len0_done", 2, t);
        chk("len0_no_rd", 32'(acc_count), 32'd0);

        // Request while busy is dropped with an error pulse.
        @(negedge clk);
        pops = 0;
        start_req(32'h002E_0000, 8'd8);
        @(negedge clk);
        req_re   = 1'b1;
        req_addr = 32'h0000_5000;
        req_len  = 8'd3;
        @(negedge clk);
        req_re = 1'b0;
        #2;
        chk("err_pulse", {31'h0, req_err}, 32'd1);
        @(negedge clk);
        #2;
        chk("err_single", {31'h0, req_err}, 32'd0);
        wait_done("err_xfer_done", 80, t);
        chk("err_xfer_pops", 32'(pops), 32'd8);

        // Reset mid-burst after 3 words.
        @(negedge clk);
        pops = 0;
        start_req(32'h0000_3000, 8'd8);
        for (int k = 0; k < 60 && pops < 3; k++) @(negedge clk);
        chk("midrst_reached", {31'h0, pops >= 3}, 32'd1);
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        #2;
        chk_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pops = 0;
        start_req(32'h0000_4000, 8'd2);
        wait_done("post_rst_done", 40, t);
        chk("post_rst_pops", 32'(pops), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog");
    end

endmodule
